nibble_fifo: RTL and testbench
==============================

# nibble_fifo

Synchronous first-in-first-out buffer for 4-bit data words, feeding the enabled 4-bit bus register in the memory datapath. A producer pushes words when space is available. A pop returns one word a cycle later as `rd_data` plus a single-cycle `rd_valid` strobe; these wire directly to the register's `d` and `en` inputs. Depth is parameterised, and an optional sticky error monitor can be compiled in.

## Interface
- `DEPTH`, default 8: number of entries; power of two, ≥ 2.
- `WIDTH`, default 4: word width in bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: push request.
- `wr_data` in WIDTH: word to push.
- `rd_en` in 1: pop request.
- `rd_data` out WIDTH: registered popped word; drives downstream `d`.
- `rd_valid` out 1: one-cycle strobe, high the cycle after an accepted pop; drives downstream `en`.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `count` out clog2(DEPTH)+1: number of stored words.
- `overflow` out 1: sticky push-while-full flag; 0 when the feature is compiled out.
- `underflow` out 1: sticky pop-while-empty flag; 0 when the feature is compiled out.

## Operation
- Storage: DEPTH × WIDTH array. Contents are not reset.
- Pointers: `wr_ptr` and `rd_ptr`, clog2(DEPTH) bits each. Each wraps from DEPTH-1 to 0 by natural overflow.
- Push accepted when `wr_en && !full`:
  - `mem[wr_ptr] <= wr_data`, then `wr_ptr` increments.
- Pop accepted when `rd_en && !empty`:
  - `rd_data <= mem[rd_ptr]`, `rd_ptr` increments, `rd_valid <= 1`.
- No accepted pop: `rd_valid <= 0`; `rd_data` holds its last value.
- Count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Flags: `full` and `empty` are decoded combinationally from the `count` register. There is no separate state.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted.
  - Empty: push accepted, pop rejected. There is no fall-through, so a word is never popped in the cycle it is written.
  - Full: pop accepted, push rejected. Space freed by a pop is usable only from the next cycle.
- Rejected requests have no effect on pointers, count or memory.
- Reset (asynchronous, any time, including mid-burst):
  - `wr_ptr`, `rd_ptr`, `count` = 0
  - `rd_data` = 0, `rd_valid` = 0
  - `overflow`, `underflow` = 0
  - `empty` = 1, `full` = 0
- First edge after reset release behaves as a normal cycle.

## Timing
- Push-to-visible: a word pushed at edge N is poppable with `rd_en` sampled at edge N+1 or later.
- Pop latency: `rd_en` sampled at edge N gives `rd_data` and `rd_valid` valid after edge N, for one cycle.
  - The downstream register captures the word at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- `full`, `empty` and `count` reflect the edge just taken. There is no combinational path from `wr_en`/`rd_en` to any output.

## Configuration
- Macro `NIBBLE_FIFO_ERR_EN`.
- Defined:
  - `overflow` sets at any edge where `wr_en && full`.
  - `underflow` sets at any edge where `rd_en && empty`.
  - Both stay set until `reset`.
  - FIFO data behaviour is unchanged.
- Undefined: `overflow` and `underflow` are tied to 0 and no error logic is synthesised. The port list is identical in both builds.

## Test plan
- Reset, then idle 3 cycles:
  - `empty`=1, `full`=0, `count`=0, `rd_valid`=0, `rd_data`=0.
- Push 0x1,0x2,0x3 on consecutive cycles, then pop 3 cycles:
  - `rd_valid` pulses 3 consecutive cycles, `rd_data` = 0x1,0x2,0x3.
  - `count` returns to 0 and `empty`=1.
- Fill DEPTH=8 with 0x0..0x7, then push 0xF:
  - `full`=1, `count`=8, 0xF dropped.
  - Popping 8 returns 0x0..0x7; with `NIBBLE_FIFO_ERR_EN`, `overflow`=1.
- Pointer wrap, 20 cycles of push+pop streaming 0x0..0xF cyclically after pre-loading 2 words:
  - Output order is preserved, `count` stays 2, no `full` or `empty`.
- Simultaneous push 0xA and pop while empty:
  - No `rd_valid` that cycle, `count`=1; the next pop returns 0xA.
  - With the macro, `underflow`=1.
- Assert `reset` mid-stream with `count`=5:
  - All outputs return to reset values asynchronously.
  - The next push/pop pair returns the new word, not stale data.

Source files
------------

// File: rtl/nibble_fifo.sv
// Synchronous FIFO for 4-bit words with a registered pop port (rd_data/rd_valid) and count-decoded flags.
// Define NIBBLE_FIFO_ERR_EN to compile in sticky overflow/underflow monitors; otherwise both are tied to 0.
module nibble_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             full_w;
    logic             empty_w;
    logic             push;
    logic             pop;

    // Flags come only from the registered count, so requests never reach outputs combinationally.
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // An empty FIFO rejects the pop even when a push lands in the same cycle (no fall-through);
    // a full FIFO rejects the push even when a pop frees a slot in the same cycle.
    assign push = wr_en && !full_w;
    assign pop  = rd_en && !empty_w;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef NIBBLE_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full_w) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;

endmodule

// File: tb/tb_nibble_fifo.sv
// Self-checking bench for nibble_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_nibble_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    nibble_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: a plain queue of stored words plus the last popped word.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_data;
    bit               m_valid;
    bit               m_ovf;
    bit               m_unf;

    typedef struct {
        bit               wr;
        logic [WIDTH-1:0] wd;
        bit               rd;
        bit               ev;
        logic [WIDTH-1:0] ed;
        int unsigned      ec;
        bit               ef;
        bit               ee;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_edge(input bit wr, input logic [WIDTH-1:0] wd, input bit rd);
        int unsigned sz;
        sz = m_q.size();
        if (wr && sz == DEPTH) m_ovf = 1'b1;
        if (rd && sz == 0)     m_unf = 1'b1;
        m_valid = 1'b0;
        if (rd && sz > 0) begin
            m_data  = m_q.pop_front();
            m_valid = 1'b1;
        end
        if (wr && sz < DEPTH) m_q.push_back(wd);
    endtask

    task automatic check_model(input string tag);
        bit exp_ovf;
        bit exp_unf;
`ifdef NIBBLE_FIFO_ERR_EN
        exp_ovf = m_ovf;
        exp_unf = m_unf;
`else
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        chk({tag, ".rd_valid"},  32'(rd_valid),  32'(m_valid));
        if (m_valid) chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_data));
        chk({tag, ".count"},     32'(count),     32'(m_q.size()));
        chk({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
        chk({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        chk({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
    endtask

    // One clock cycle: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input bit wr, input logic [WIDTH-1:0] wd, input bit rd, input string tag);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        @(posedge clk);
        model_edge(wr, wd, rd);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".rst_count"},     32'(count),     32'd0);
        chk({tag, ".rst_empty"},     32'(empty),     32'd1);
        chk({tag, ".rst_full"},      32'(full),      32'd0);
        chk({tag, ".rst_rd_valid"},  32'(rd_valid),  32'd0);
        chk({tag, ".rst_rd_data"},   32'(rd_data),   32'd0);
        chk({tag, ".rst_overflow"},  32'(overflow),  32'd0);
        chk({tag, ".rst_underflow"}, 32'(underflow), 32'd0);
    endtask

    function automatic vec_t mk(bit wr, logic [WIDTH-1:0] wd, bit rd, bit ev,
                                logic [WIDTH-1:0] ed, int unsigned ec, bit ef, bit ee);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef; v.ee = ee;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        reset   = 1'b1;
        model_reset();

        // Directed table: idle, push/pop three, fill + drop, drain, push+pop while empty.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(1, 4'h1, 0, 0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(1, 4'h2, 0, 0, 4'h0, 2, 0, 0));
        vecs.push_back(mk(1, 4'h3, 0, 0, 4'h0, 3, 0, 0));
        vecs.push_back(mk(0, 4'h0, 1, 1, 4'h1, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 1, 1, 4'h2, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 1, 1, 4'h3, 0, 0, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 4'h3, 0, 0, 1));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 4'(i), 0, 0, 4'h3, i + 1, i == 7, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 4'h3, 8, 1, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 4'h0, 1, 1, 4'(i), 7 - i, 0, i == 7));
        vecs.push_back(mk(1, 4'hA, 1, 0, 4'h7, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 1, 1, 4'hA, 0, 0, 1));

        #12;
        check_reset_outputs("init");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rd, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.t_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d.t_data", i),  32'(rd_data),  32'(vecs[i].ed));
            chk($sformatf("vec%0d.t_count", i), 32'(count),    32'(vecs[i].ec));
            chk($sformatf("vec%0d.t_full", i),  32'(full),     32'(vecs[i].ef));
            chk($sformatf("vec%0d.t_empty", i), 32'(empty),    32'(vecs[i].ee));
        end

        // Pointer wrap: preload two words, then stream push+pop for 20 cycles.
        step(1, 4'h0, 0, "wrap_pre0");
        step(1, 4'h1, 0, "wrap_pre1");
        for (int i = 2; i < 22; i++) begin
            step(1, 4'(i % 16), 1, $sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d.order", i), 32'(rd_data), 32'((i - 2) % 16));
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'd2);
        end
        step(0, 4'h0, 1, "wrap_drain0");
        step(0, 4'h0, 1, "wrap_drain1");

        // Mid-stream asynchronous reset with five words stored.
        for (int i = 0; i < 5; i++) step(1, 4'(4'h9 - i), 0, $sformatf("mid_fill%0d", i));
        chk("mid.count5", 32'(count), 32'd5);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1, 4'hB, 0, "post_rst_push");
        step(0, 4'h0, 1, "post_rst_pop");
        chk("post_rst.word", 32'(rd_data), 32'hB);

        // Randomized traffic, biased to visit both full and empty.
        for (int i = 0; i < 400; i++) begin
            bit wr;
            bit rd;
            int unsigned bias;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            wr = ($urandom_range(99) < bias);
            rd = ($urandom_range(99) < (100 - bias));
            step(wr, 4'($urandom), rd, $sformatf("rnd%0d", i));
        end

        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
